// File: rtl/alu_pkg.sv
// Shared ALU opcode / flag definitions and scheduler state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_PASS = 4'b1111;

    localparam int FLAG_ZF = 0;
    localparam int FLAG_SF = 1;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } sched_state_t;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int IW = $clog2(NREQ);

    int   idx;
    logic found;

    // Walk the requesters from ptr, modulo NREQ, and keep the first hit.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered 64-bit ALU between NREQ clients.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [4*NREQ-1:0]         req_op,
    input  logic [W*NREQ-1:0]         req_a,
    input  logic [W*NREQ-1:0]         req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [W-1:0]              rsp_y,
    output logic [3:0]                rsp_flags,
    output logic [3:0]                alu_op,
    output logic [W-1:0]              alu_a,
    output logic [W-1:0]              alu_b,
    input  logic [W-1:0]              alu_y,
    input  logic                      alu_zf,
    input  logic                      alu_sf,
    input  logic                      alu_cf,
    input  logic                      alu_of,
    output logic                      busy,
    output logic [31:0]               done_cnt
);

    localparam int IW = $clog2(NREQ);

    sched_state_t    state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   id_q;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;

    logic [3:0]   op_arr [NREQ];
    logic [W-1:0] a_arr  [NREQ];
    logic [W-1:0] b_arr  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign op_arr[i] = req_op[4*i +: 4];
        assign a_arr[i]  = req_a[W*i +: W];
        assign b_arr[i]  = req_b[W*i +: W];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (state == IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The grant itself is the ready: one-hot in IDLE, zero elsewhere.
    assign req_ready = gnt;

    // Scheduler FSM: accept -> ALU executes -> capture -> hold response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            id_q      <= '0;
            alu_op    <= OP_PASS;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_flags <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        alu_op <= op_arr[gnt_idx];
                        alu_a  <= a_arr[gnt_idx];
                        alu_b  <= b_arr[gnt_idx];
                        id_q   <= gnt_idx;
                        ptr    <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                // ALU registers its result on this edge.
                EXEC: state <= CAPT;
                CAPT: begin
                    rsp_y                <= alu_y;
                    rsp_flags[FLAG_OF]   <= alu_of;
                    rsp_flags[FLAG_CF]   <= alu_cf;
                    rsp_flags[FLAG_SF]   <= alu_sf;
                    rsp_flags[FLAG_ZF]   <= alu_zf;
                    rsp_id               <= id_q;
                    rsp_valid            <= 1'b1;
                    state                <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completed response handshakes; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            done_cnt <= '0;
        else if (rsp_valid && rsp_ready)
            done_cnt <= done_cnt + 32'd1;
    end

endmodule

// File: tb/tb_alu_sched.sv
// Randomized bench for alu_sched with a behavioural ALU and a cycle-level reference model.
module tb_alu_sched;
    import alu_pkg::*;

    localparam int N = 4;
    localparam int W = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [4*N-1:0]  req_op = '0;
    logic [W*N-1:0]  req_a = '0;
    logic [W*N-1:0]  req_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_y;
    logic [3:0]      rsp_flags;
    logic [3:0]      alu_op;
    logic [W-1:0]    alu_a, alu_b;
    logic [W-1:0]    alu_y;
    logic            alu_zf, alu_sf, alu_cf, alu_of;
    logic            busy;
    logic [31:0]     done_cnt;

    always #5 clk = ~clk;

    alu_sched #(.NREQ(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_cf(alu_cf), .alu_of(alu_of),
        .busy(busy), .done_cnt(done_cnt)
    );

    // Returns {OF,CF,SF,ZF, y}
    function automatic logic [67:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        logic [63:0] y;
        logic cf, of;
        cf = 1'b0; of = 1'b0; s = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b}; y = s[63:0]; cf = s[64];
                of = (a[63] == b[63]) && (y[63] != a[63]);
            end
            OP_SUB: begin
                y = a - b; cf = (a < b);
                of = (a[63] != b[63]) && (y[63] != a[63]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MUL:  y = a * b;
            OP_PASS: y = a;
            default: y = '0;
        endcase
        return {of, cf, y[63], (y == 64'd0), y};
    endfunction

    // External registered ALU (no reset)
    always @(posedge clk) begin
        logic [67:0] r;
        r = alu_f(alu_op, alu_a, alu_b);
        alu_y  <= r[63:0];
        alu_zf <= r[64];
        alu_sf <= r[65];
        alu_cf <= r[66];
        alu_of <= r[67];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          cyc = 0;
    int          m_ptr = 0;
    bit          m_busy = 0;
    int          m_acc = 0;
    logic [31:0] m_cnt = '0;
    int          m_id;
    logic [63:0] m_y;
    logic [3:0]  m_f;
    int          g_id[$];
    int          g_cyc[$];
    int          last_id, hs_cyc;
    logic [63:0] last_y;
    logic [3:0]  last_f;

    always @(negedge clk) begin
        int w;
        logic [N-1:0] exp_rdy;
        bit rv;
        logic [67:0] r;
        cyc++;
        if (rst) begin
            m_ptr = 0; m_busy = 0; m_cnt = '0;
        end else begin
            w = -1;
            exp_rdy = '0;
            if (!m_busy)
                for (int i = 0; i < N; i++)
                    if (w < 0 && req_valid[(m_ptr + i) % N]) w = (m_ptr + i) % N;
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done_cnt", 64'(done_cnt), 64'(m_cnt));
            rv = m_busy && (cyc >= m_acc + 3);
            chk("rsp_valid", 64'(rsp_valid), 64'(rv));
            if (rv) begin
                chk("rsp_id", 64'(rsp_id), 64'(m_id));
                chk("rsp_y", rsp_y, m_y);
                chk("rsp_flags", 64'(rsp_flags), 64'(m_f));
                if (rsp_ready) begin
                    m_busy = 0; m_cnt = m_cnt + 32'd1;
                    last_id = m_id; last_y = m_y; last_f = m_f; hs_cyc = cyc;
                end
            end
            if (w >= 0) begin
                r = alu_f(req_op[w*4 +: 4], req_a[w*W +: W], req_b[w*W +: W]);
                m_id = w; m_y = r[63:0]; m_f = r[67:64];
                m_busy = 1; m_acc = cyc; m_ptr = (w + 1) % N;
                g_id.push_back(w); g_cyc.push_back(cyc);
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        req_op[i*4 +: 4] = op;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    task automatic wait_grants(input int n);
        int k = 0;
        while (g_id.size() < n && k < 200) begin
            @(posedge clk); #1; k++;
        end
        chk("grant_count", 64'(g_id.size()), 64'(n));
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (m_busy && k < 200);
        chk("idle_reached", 64'(m_busy), 64'd0);
    endtask

    logic [3:0] ops [7];
    initial begin
        int base, t_raise;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_PASS};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_y", rsp_y, 64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'hF);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_b", alu_b, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);
        rst = 1'b0;

        // Round-robin from reset
        for (int i = 0; i < N; i++) set_req(i, OP_SUB, 64'd10, 64'd3);
        req_valid = 4'b1111;
        base = g_id.size();
        wait_grants(base + 5);
        req_valid = '0;
        wait_idle();
        for (int i = 0; i < 5; i++) chk("rr_order", 64'(g_id[base+i]), 64'(i % 4));
        for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(g_cyc[base+i] - g_cyc[base+i-1]), 64'd4);
        chk("rr_y", last_y, 64'd7);

        // Single op: carry out of all-ones + 1
        set_req(0, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        req_valid = 4'b0001;
        base = g_id.size();
        wait_grants(base + 1);
        req_valid = '0;
        wait_idle();
        chk("single_id", 64'(last_id), 64'd0);
        chk("single_y", last_y, 64'd0);
        chk("single_flags", 64'(last_f), 64'h5);
        chk("single_hs_lat", 64'(hs_cyc - g_cyc[base]), 64'd3);
        chk("single_done", 64'(done_cnt), 64'd6);

        // Back-pressure on requester 2
        rsp_ready = 1'b0;
        set_req(2, OP_MUL, 64'd6, 64'd7);
        for (int i = 0; i < N; i++) if (i != 2) set_req(i, OP_PASS, 64'd1, 64'd0);
        req_valid = 4'b0100;
        base = g_id.size();
        wait_grants(base + 1);
        req_valid = 4'b1011;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_no_grant", 64'(g_id.size()), 64'(base + 1));
        chk("bp_rsp_y", rsp_y, 64'd42);
        chk("bp_rsp_id", 64'(rsp_id), 64'd2);
        t_raise = cyc;
        rsp_ready = 1'b1;
        req_valid = '0;
        wait_idle();
        chk("bp_hs_cycle", 64'(hs_cyc), 64'(t_raise + 1));
        chk("bp_last_y", last_y, 64'd42);

        // Pointer wrap
        set_req(3, OP_XOR, 64'hF0, 64'h0F);
        set_req(0, OP_OR, 64'h100, 64'h1);
        req_valid = 4'b1000;
        base = g_id.size();
        wait_grants(base + 1);
        req_valid = '0;
        wait_idle();
        req_valid = 4'b1001;
        wait_grants(base + 2);
        req_valid = '0;
        wait_idle();
        chk("wrap_first", 64'(g_id[base]), 64'd3);
        chk("wrap_second", 64'(g_id[base+1]), 64'd0);

        // Counter wrap
        m_cnt = 32'hFFFF_FFFF;
        force dut.done_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.done_cnt;
        set_req(1, OP_ADD, 64'd2, 64'd2);
        req_valid = 4'b0010;
        base = g_id.size();
        wait_grants(base + 1);
        req_valid = '0;
        wait_idle();
        chk("cnt_wrap", 64'(done_cnt), 64'd0);

        // Reset mid-op in CAPT
        set_req(1, OP_SUB, 64'd5, 64'd9);
        req_valid = 4'b0010;
        base = g_id.size();
        wait_grants(base + 1);
        req_valid = '0;
        @(posedge clk); #2;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, OP_AND, 64'hFF00, 64'h0FF0);
        req_valid = 4'b0011;
        base = g_id.size();
        wait_grants(base + 1);
        req_valid = '0;
        wait_idle();
        chk("post_rst_grant", 64'(g_id[base]), 64'd0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(i, ops[$urandom_range(0, 6)], {$urandom, $urandom}, {$urandom, $urandom});
                else
                    set_req(i, ops[$urandom_range(0, 6)], 64'($urandom_range(0, 20)), 64'($urandom_range(0, 20)));
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
